// File: rtl/dino_key_scheduler.sv
// Dino player key sequencer: debounced LDR requests -> timed SPACEBAR/DOWNKEY presses with cooldown.
// Optional macro DINO_DUCK_EXTEND_EN: duck continues while the duck sensor stays high, capped at DUCK_MAX_CYC.
module dino_key_scheduler #(
    parameter int unsigned DEBOUNCE_CYC  = 50000,
    parameter int unsigned JUMP_HOLD_CYC = 5000000,
    parameter int unsigned DUCK_HOLD_CYC = 15000000,
    parameter int unsigned DUCK_MAX_CYC  = 50000000,
    parameter int unsigned COOLDOWN_CYC  = 2500000
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       GPILDR1,
    input  logic       GPILDR2,
    output logic       SPACEBAR,
    output logic       DOWNKEY,
    output logic       BUSY,
    output logic [7:0] LEDG
);

    function automatic int unsigned at_least_one(input int unsigned v);
        return (v == 0) ? 1 : v;
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned DEB_C   = at_least_one(DEBOUNCE_CYC);
    localparam int unsigned JUMP_C  = at_least_one(JUMP_HOLD_CYC);
    localparam int unsigned DUCK_C  = at_least_one(DUCK_HOLD_CYC);
    localparam int unsigned DMAX_C  = max2(at_least_one(DUCK_MAX_CYC), DUCK_C);
    localparam int unsigned COOL_C  = at_least_one(COOLDOWN_CYC);
    localparam int unsigned MAX_CYC = max2(max2(DEB_C, JUMP_C), max2(DMAX_C, COOL_C));
    localparam int unsigned CW      = $clog2(MAX_CYC) + 1;
    localparam int unsigned DBW     = $clog2(DEB_C) + 1;

`ifdef DINO_DUCK_EXTEND_EN
    localparam int unsigned DUCK_LOAD = DMAX_C - 1;
`else
    localparam int unsigned DUCK_LOAD = DUCK_C - 1;
`endif

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_JUMP = 2'b01;
    localparam logic [1:0] ST_DUCK = 2'b10;
    localparam logic [1:0] ST_COOL = 2'b11;

    // Channel index 0 = jump (GPILDR1), 1 = duck (GPILDR2).
    logic [1:0]          raw;
    logic [1:0]          sync1_q, sync1_d, sync2_q, sync2_d;
    logic [1:0]          deb_q, deb_d, deb_prev_q, deb_prev_d;
    logic [1:0][DBW-1:0] db_cnt_q, db_cnt_d;
    logic [1:0]          rise;
    logic                jump_pend_q, jump_pend_d, duck_pend_q, duck_pend_d;
    logic [1:0]          state_q, state_d, state_out_q, state_out_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                spacebar_q, spacebar_d, downkey_q, downkey_d, busy_q, busy_d;
    logic                grant_jump, grant_duck;

    assign raw = {GPILDR2, GPILDR1};

    always_comb begin
        sync1_d    = raw;
        sync2_d    = sync1_q;
        deb_prev_d = deb_q;
        deb_d      = deb_q;
        db_cnt_d   = db_cnt_q;
        rise       = deb_q & ~deb_prev_q;
        for (int unsigned i = 0; i < 2; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                if (db_cnt_q[i] == DBW'(DEB_C - 1)) begin
                    deb_d[i]    = ~deb_q[i];
                    db_cnt_d[i] = '0;
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DBW'(1);
                end
            end else begin
                db_cnt_d[i] = '0;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        grant_jump = 1'b0;
        grant_duck = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (jump_pend_q) begin
                    state_d    = ST_JUMP;
                    cnt_d      = CW'(JUMP_C - 1);
                    grant_jump = 1'b1;
                end else if (duck_pend_q) begin
                    state_d    = ST_DUCK;
                    cnt_d      = CW'(DUCK_LOAD);
                    grant_duck = 1'b1;
                end
            end
            ST_JUMP: begin
                if (cnt_q == '0) begin
                    state_d = ST_COOL;
                    cnt_d   = CW'(COOL_C - 1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_DUCK: begin
`ifdef DINO_DUCK_EXTEND_EN
                // Counter runs down from the cap; the minimum hold is met once it falls to DMAX-DUCK.
                if ((cnt_q == '0) || ((cnt_q <= CW'(DMAX_C - DUCK_C)) && !deb_q[1])) begin
`else
                if (cnt_q == '0) begin
`endif
                    state_d = ST_COOL;
                    cnt_d   = CW'(COOL_C - 1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
        endcase

        // A new edge in the grant cycle wins over the clear.
        jump_pend_d = rise[0] | (jump_pend_q & ~grant_jump);
        duck_pend_d = rise[1] | (duck_pend_q & ~grant_duck);

        spacebar_d  = (state_q == ST_JUMP);
        downkey_d   = (state_q == ST_DUCK);
        busy_d      = (state_q != ST_IDLE);
        state_out_d = state_q;
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            deb_q       <= '0;
            deb_prev_q  <= '0;
            db_cnt_q    <= '0;
            jump_pend_q <= 1'b0;
            duck_pend_q <= 1'b0;
            state_q     <= ST_IDLE;
            state_out_q <= ST_IDLE;
            cnt_q       <= '0;
            spacebar_q  <= 1'b0;
            downkey_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            deb_q       <= deb_d;
            deb_prev_q  <= deb_prev_d;
            db_cnt_q    <= db_cnt_d;
            jump_pend_q <= jump_pend_d;
            duck_pend_q <= duck_pend_d;
            state_q     <= state_d;
            state_out_q <= state_out_d;
            cnt_q       <= cnt_d;
            spacebar_q  <= spacebar_d;
            downkey_q   <= downkey_d;
            busy_q      <= busy_d;
        end
    end

    assign SPACEBAR = spacebar_q;
    assign DOWNKEY  = downkey_q;
    assign BUSY     = busy_q;
    assign LEDG     = {2'b00, state_out_q, duck_pend_q, jump_pend_q, downkey_q, spacebar_q};

endmodule

// File: tb/tb_dino_key_scheduler.sv
// Directed bench for dino_key_scheduler with small timing parameters; edge n is the n-th clock after reset release.
module tb_dino_key_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       g1, g2;
    logic       spacebar, downkey, busy;
    logic [7:0] ledg;

    always #5 clk = ~clk;

    dino_key_scheduler #(
        .DEBOUNCE_CYC (4),
        .JUMP_HOLD_CYC(10),
        .DUCK_HOLD_CYC(20),
        .DUCK_MAX_CYC (40),
        .COOLDOWN_CYC (5)
    ) dut (
        .CLOCK_50(clk),
        .RESET   (rst),
        .GPILDR1 (g1),
        .GPILDR2 (g2),
        .SPACEBAR(spacebar),
        .DOWNKEY (downkey),
        .BUSY    (busy),
        .LEDG    (ledg)
    );

    localparam int WIN = 100;

    typedef struct {
        string name;
        int    h1, h2;
        int    sp_first, sp_len, dk_first, dk_len;
        int    busy_first, busy_last, dpend_last;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    int sp_first, sp_len, sp_rises, dk_first, dk_len, dk_rises;
    int busy_first, busy_last, dpend_last, bad_inv;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        g1  = 1'b1;
        g2  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Releases reset and drives the sensors for WIN edges, collecting key/busy statistics.
    task automatic run_window(input int h1, input int h2, input bit pulse_mode);
        bit prev_sp = 1'b0, prev_dk = 1'b0;
        sp_first = -1; sp_len = 0; sp_rises = 0;
        dk_first = -1; dk_len = 0; dk_rises = 0;
        busy_first = -1; busy_last = -1; dpend_last = -1; bad_inv = 0;
        for (int n = 0; n < WIN; n++) begin
            rst = 1'b0;
            if (pulse_mode)
                g1 = (n >= 2) && (n < 26) && (((n - 2) % 8) < 4);
            else
                g1 = (n < h1);
            g2 = (n < h2);
            @(posedge clk);
            #1;
            if (spacebar) begin
                if (sp_first < 0) sp_first = n;
                sp_len++;
                if (!prev_sp) sp_rises++;
            end
            if (downkey) begin
                if (dk_first < 0) dk_first = n;
                dk_len++;
                if (!prev_dk) dk_rises++;
            end
            if (busy) begin
                if (busy_first < 0) busy_first = n;
                busy_last = n;
            end
            if (ledg[3]) dpend_last = n;
            if (spacebar && downkey) bad_inv++;
            if (ledg[0] != spacebar || ledg[1] != downkey || ledg[7:6] != 2'b00 ||
                busy != (ledg[5:4] != 2'b00)) bad_inv++;
            prev_sp = spacebar;
            prev_dk = downkey;
        end
        g1 = 1'b0;
        g2 = 1'b0;
    endtask

    vec_t vecs[5];

    initial begin
`ifdef DINO_DUCK_EXTEND_EN
        vecs[0] = '{"single_jump", 100, 0,   8, 10, -1, 0,  8, 22, -1};
        vecs[1] = '{"glitch",      0,   3,  -1, 0,  -1, 0, -1, -1, -1};
        vecs[2] = '{"simultaneous",100, 100, 8, 10, 24, 40, 8, 68, 22};
        vecs[3] = '{"duck60",      0,   60, -1, 0,   8, 40, 8, 52, 6};
        vecs[4] = '{"duck30",      0,   30, -1, 0,   8, 29, 8, 41, 6};
`else
        vecs[0] = '{"single_jump", 100, 0,   8, 10, -1, 0,  8, 22, -1};
        vecs[1] = '{"glitch",      0,   3,  -1, 0,  -1, 0, -1, -1, -1};
        vecs[2] = '{"simultaneous",100, 100, 8, 10, 24, 20, 8, 48, 22};
        vecs[3] = '{"duck60",      0,   60, -1, 0,   8, 20, 8, 32, 6};
        vecs[4] = '{"duck30",      0,   30, -1, 0,   8, 20, 8, 32, 6};
`endif

        // Reset with both sensors high.
        do_reset();
        chk("reset_spacebar", int'(spacebar), 0);
        chk("reset_downkey",  int'(downkey),  0);
        chk("reset_busy",     int'(busy),     0);
        chk("reset_ledg",     int'(ledg),     0);

        foreach (vecs[k]) begin
            do_reset();
            run_window(vecs[k].h1, vecs[k].h2, 1'b0);
            chk({vecs[k].name, "_sp_first"},   sp_first,   vecs[k].sp_first);
            chk({vecs[k].name, "_sp_len"},     sp_len,     vecs[k].sp_len);
            chk({vecs[k].name, "_dk_first"},   dk_first,   vecs[k].dk_first);
            chk({vecs[k].name, "_dk_len"},     dk_len,     vecs[k].dk_len);
            chk({vecs[k].name, "_busy_first"}, busy_first, vecs[k].busy_first);
            chk({vecs[k].name, "_busy_last"},  busy_last,  vecs[k].busy_last);
            chk({vecs[k].name, "_dpend_last"}, dpend_last, vecs[k].dpend_last);
            chk({vecs[k].name, "_sp_rises"},   sp_rises,   (vecs[k].sp_len > 0) ? 1 : 0);
            chk({vecs[k].name, "_dk_rises"},   dk_rises,   (vecs[k].dk_len > 0) ? 1 : 0);
            chk({vecs[k].name, "_invariants"}, bad_inv,    0);
        end

        // Coalescing: one duck, three debounced jump edges during it, one jump afterwards.
        do_reset();
        g2 = 1'b0;
        run_window(0, 8, 1'b1);
        chk("coalesce_dk_first", dk_first, 8);
        chk("coalesce_dk_len",   dk_len,   20);
        chk("coalesce_sp_first", sp_first, 34);
        chk("coalesce_sp_len",   sp_len,   10);
        chk("coalesce_sp_rises", sp_rises, 1);
        chk("coalesce_inv",      bad_inv,  0);

        // Reset during the fifth SPACEBAR cycle.
        do_reset();
        for (int n = 0; n <= 12; n++) begin
            rst = 1'b0;
            g1  = 1'b1;
            g2  = 1'b0;
            @(posedge clk);
            #1;
        end
        chk("midreset_sp_before", int'(spacebar), 1);
        rst = 1'b1;
        g1  = 1'b0;
        @(posedge clk);
        #1;
        chk("midreset_sp_after",   int'(spacebar), 0);
        chk("midreset_busy_after", int'(busy),     0);
        chk("midreset_ledg_after", int'(ledg),     0);
        run_window(0, 0, 1'b0);
        chk("midreset_no_replay_sp",   sp_len,     0);
        chk("midreset_no_replay_busy", busy_first, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
